icache_refill_ctrl: RTL and testbench

Miss-refill sequencer between the I-cache lookup datapath and the downstream AHB-Lite master port. It accepts one line-miss request at a time and issues a critical-word-first WRAP burst (word-aligned address, word size). It assembles the returned beats into a full cache line in address order and hands the line, index and tag back to the cache array in a single update pulse. It also owns downstream HTRANS/HBURST/HADDR sequencing, including wait states and ERROR responses.

---
 rtl/icache_refill_ctrl_if.sv | 44 ++++
 rtl/icache_refill_ctrl.sv | 134 +++++++++++++
 tb/tb_icache_refill_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_if.sv
// Refill request/response and AHB-Lite master bundle for icache_refill_ctrl.
// master = refill controller side, slave = cache + downstream bus side.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 256
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - $clog2(LINE_WORDS * 4);

    logic                    miss_req;
    logic [ADDR_W-1:0]       miss_addr;
    logic                    miss_ack;
    logic                    busy;
    logic                    refill_done;
    logic [32*LINE_WORDS-1:0] refill_line;
    logic [IDX_W-1:0]        refill_index;
    logic [TAG_W-1:0]        refill_tag;
    logic                    refill_err;
    logic                    crit_valid;
    logic [31:0]             crit_data;
    logic [ADDR_W-1:0]       m_haddr;
    logic [1:0]              m_htrans;
    logic [2:0]              m_hburst;
    logic [2:0]              m_hsize;
    logic                    m_hwrite;
    logic [31:0]             m_hrdata;
    logic                    m_hready;
    logic                    m_hresp;

    modport master (
        input  miss_req, miss_addr, m_hrdata, m_hready, m_hresp,
        output miss_ack, busy, refill_done, refill_line, refill_index, refill_tag,
               refill_err, crit_valid, crit_data,
               m_haddr, m_htrans, m_hburst, m_hsize, m_hwrite
    );

    modport slave (
        output miss_req, miss_addr, m_hrdata, m_hready, m_hresp,
        input  miss_ack, busy, refill_done, refill_line, refill_index, refill_tag,
               refill_err, crit_valid, crit_data,
               m_haddr, m_htrans, m_hburst, m_hsize, m_hwrite
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// I-cache miss refill: one critical-word-first AHB WRAP burst per miss, line returned LINE_WORDS+2 cycles after ack (zero wait).
// Stalls on m_hready=0, aborts on ERROR; optional critical-word forward under ICACHE_CRIT_WORD_FWD_EN.
module icache_refill_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 256
) (
    input  logic                  hclk,
    input  logic                  hrst,
    icache_refill_ctrl_if.master  bus
);
    localparam int WO_W  = $clog2(LINE_WORDS);
    localparam int OFF_W = WO_W + 2;
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam logic [WO_W:0] LW_C = (WO_W+1)'(LINE_WORDS);
    localparam logic [WO_W:0] LAST = LW_C - 1'b1;
    localparam logic [2:0] BURST = (LINE_WORDS == 16) ? 3'b110 :
                                   (LINE_WORDS == 8)  ? 3'b100 : 3'b010;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_ERR1, S_ERR2} state_t;
    state_t state_q, state_d;

    logic [ADDR_W-1:2]        lbase_q;
    logic [WO_W:0]            acnt_q, dcnt_q;
    logic [31:0]              buf_q [LINE_WORDS];
    logic [32*LINE_WORDS-1:0] line_q;
    logic [IDX_W-1:0]         index_q;
    logic [TAG_W-1:0]         tag_q;
    logic [WO_W-1:0]          aword, dword;
    logic [1:0]               htrans;
    logic                     data_ok;
    logic                     unused_addr_bits;

    assign unused_addr_bits = ^bus.miss_addr[1:0];

    // Beat k of the burst sits at word (start + k) mod LINE_WORDS; the upper bits never move.
    assign aword   = lbase_q[OFF_W-1:2] + acnt_q[WO_W-1:0];
    assign dword   = lbase_q[OFF_W-1:2] + dcnt_q[WO_W-1:0];
    assign data_ok = (state_q == S_DATA) && bus.m_hready && !bus.m_hresp;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        htrans  = 2'b00;
        unique case (state_q)
            S_IDLE: if (bus.miss_req) state_d = S_ADDR;
            S_ADDR: begin
                htrans = 2'b10;
                if (bus.m_hready) state_d = S_DATA;
            end
            S_DATA: begin
                if (acnt_q != LW_C) htrans = 2'b11;
                if (bus.m_hresp)                          state_d = bus.m_hready ? S_ERR2 : S_ERR1;
                else if (bus.m_hready && dcnt_q == LAST)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            lbase_q <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            line_q  <= '0;
            index_q <= '0;
            tag_q   <= '0;
        end else begin
            if (state_q == S_IDLE && bus.miss_req) begin
                lbase_q <= bus.miss_addr[ADDR_W-1:2];
                acnt_q  <= '0;
                dcnt_q  <= '0;
            end
            if (state_q == S_ADDR && bus.m_hready) acnt_q <= acnt_q + 1'b1;
            if (data_ok) begin
                dcnt_q <= dcnt_q + 1'b1;
                if (acnt_q != LW_C) acnt_q <= acnt_q + 1'b1;
                // Last beat bypasses the buffer so the line is complete in the DONE cycle.
                if (dcnt_q == LAST) begin
                    for (int k = 0; k < LINE_WORDS; k++)
                        line_q[32*k +: 32] <= (WO_W'(k) == dword) ? bus.m_hrdata : buf_q[k];
                    index_q <= lbase_q[OFF_W +: IDX_W];
                    tag_q   <= lbase_q[ADDR_W-1 -: TAG_W];
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (data_ok) buf_q[dword] <= bus.m_hrdata;
    end

`ifdef ICACHE_CRIT_WORD_FWD_EN
    logic        crit_vld_q;
    logic [31:0] crit_dat_q;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            crit_vld_q <= 1'b0;
            crit_dat_q <= '0;
        end else begin
            crit_vld_q <= data_ok && (dcnt_q == '0);
            if (data_ok && dcnt_q == '0) crit_dat_q <= bus.m_hrdata;
        end
    end

    assign bus.crit_valid = crit_vld_q;
    assign bus.crit_data  = crit_dat_q;
`else
    assign bus.crit_valid = 1'b0;
    assign bus.crit_data  = '0;
`endif

    assign bus.miss_ack     = bus.miss_req && (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.refill_done  = (state_q == S_DONE);
    assign bus.refill_err   = (state_q == S_ERR2);
    assign bus.refill_line  = line_q;
    assign bus.refill_index = index_q;
    assign bus.refill_tag   = tag_q;
    assign bus.m_haddr      = {lbase_q[ADDR_W-1:OFF_W], aword, 2'b00};
    assign bus.m_htrans     = htrans;
    assign bus.m_hburst     = BURST;
    assign bus.m_hsize      = 3'b010;
    assign bus.m_hwrite     = 1'b0;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Scoreboard bench for icache_refill_ctrl: directed refills, then randomized misses against an AHB slave model.
module tb_icache_refill_ctrl;
    localparam int ADDR_W = 32, LW = 4, NUM_LINES = 256;
    localparam int OFF_W  = $clog2(LW * 4);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

    typedef struct { logic [31:0] addr; int err_beat; int wait_beat; int wait_pct; } cfg_t;
    typedef struct { bit is_err; logic [32*LW-1:0] line; logic [IDX_W-1:0] index;
                     logic [TAG_W-1:0] tag; logic [31:0] crit; } exp_t;

    logic hclk = 1'b0;
    logic hrst = 1'b1;
    always #5 hclk = ~hclk;

    icache_refill_ctrl_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .NUM_LINES(NUM_LINES)) bus();
    icache_refill_ctrl #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .NUM_LINES(NUM_LINES)) dut (
        .hclk(hclk), .hrst(hrst), .bus(bus));

    int checks = 0, errors = 0, cyc = 0;
    int n_issued = 0, n_end = 0, last_end_cyc = -100, ack_cyc = 0, crit_cyc = -100;
    logic [31:0] seed;
    cfg_t slave_q[$];
    exp_t exp_q[$];

    always @(posedge hclk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic cfg_t mk(input logic [31:0] a, input int eb, input int wb, input int pct);
        cfg_t c;
        c.addr = a; c.err_beat = eb; c.wait_beat = wb; c.wait_pct = pct;
        return c;
    endfunction

    // Expected address of beat b: wrap within the line starting at the missing word.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int b);
        logic [31:0] lb = a & ~32'(LW*4-1);
        int off = int'(a & 32'(LW*4-1)) & ~3;
        return lb + 32'((off + 4*b) % (LW*4));
    endfunction

    function automatic exp_t model(input cfg_t c);
        exp_t e;
        logic [31:0] lb = c.addr & ~32'(LW*4-1);
        e.is_err = (c.err_beat >= 0);
        for (int k = 0; k < LW; k++) e.line[32*k +: 32] = mem(lb + 32'(4*k));
        e.index = c.addr[OFF_W +: IDX_W];
        e.tag   = c.addr[ADDR_W-1 -: TAG_W];
        e.crit  = mem(c.addr & ~32'h3);
        return e;
    endfunction

    task automatic chk(input string name, input logic [32*LW-1:0] act, input logic [32*LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT response within cycle budget", name);
    endtask

    task automatic issue(input cfg_t c);
        exp_t e = model(c);
        @(posedge hclk); #1;
        slave_q.push_back(c);
        exp_q.push_back(e);
        n_issued++;
        bus.miss_req  = 1'b1;
        bus.miss_addr = c.addr;
        for (int i = 0; ; i++) begin
            @(negedge hclk);
            if (bus.miss_ack) break;
            if (i == 300) begin timeout("miss_ack"); break; end
        end
        ack_cyc = cyc;
        @(posedge hclk); #1;
        bus.miss_req  = 1'b0;
        bus.miss_addr = $urandom;
    endtask

    task automatic wait_end();
        for (int i = 0; n_end < n_issued; i++) begin
            @(negedge hclk);
            if (i == 500) begin timeout("refill_end"); n_end = n_issued; end
        end
    endtask

    // Monitor: pops the scoreboard on every done/err pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (hrst) continue;
            if (bus.refill_done || bus.refill_err) begin
                n_end++;
                last_end_cyc = cyc;
                if (exp_q.size() == 0) begin
                    timeout("unexpected_end_pulse");
                end else begin
                    e = exp_q.pop_front();
                    chk("end_is_err", bus.refill_err, e.is_err);
                    chk("end_is_done", bus.refill_done, !e.is_err);
                    if (bus.refill_done && !e.is_err) begin
                        chk("refill_line", bus.refill_line, e.line);
                        chk("refill_index", bus.refill_index, e.index);
                        chk("refill_tag", bus.refill_tag, e.tag);
                    end
                end
            end
`ifdef ICACHE_CRIT_WORD_FWD_EN
            if (bus.crit_valid) begin
                crit_cyc = cyc;
                if (exp_q.size() != 0) chk("crit_data", bus.crit_data, exp_q[0].crit);
            end
`else
            chk("crit_off", {bus.crit_valid, bus.crit_data}, 33'd0);
`endif
        end
    end

    // AHB-Lite slave model with wait states and two-cycle ERROR responses.
    initial begin
        cfg_t c;
        bit dp, errp, in_burst, prev_wait;
        int beat, dbeat;
        logic [31:0] dp_addr, prev_ad;
        logic [1:0] prev_tr;
        dp = 0; errp = 0; in_burst = 0; prev_wait = 0; beat = 0; dbeat = 0;
        dp_addr = 0; prev_ad = 0; prev_tr = 0;
        c = mk(0, -1, -1, 0);
        bus.m_hready = 1'b1; bus.m_hresp = 1'b0; bus.m_hrdata = '0;
        forever begin
            @(negedge hclk);
            if (hrst) begin
                dp = 0; errp = 0; in_burst = 0; prev_wait = 0;
                bus.m_hready = 1'b1; bus.m_hresp = 1'b0;
                continue;
            end
            if (prev_wait) begin
                chk("wait_hold_htrans", bus.m_htrans, prev_tr);
                chk("wait_hold_haddr", bus.m_haddr, prev_ad);
            end
            bus.m_hready = 1'b1;
            bus.m_hresp  = 1'b0;
            bus.m_hrdata = $urandom;
            if (errp) begin
                bus.m_hresp = 1'b1;
                errp = 0; dp = 0; in_burst = 0;
                chk("err2_htrans_idle", bus.m_htrans, 2'b00);
            end else if (dp) begin
                if (dbeat == c.err_beat) begin
                    bus.m_hready = 1'b0; bus.m_hresp = 1'b1; errp = 1;
                end else if (dbeat == c.wait_beat || $urandom_range(99) < c.wait_pct) begin
                    bus.m_hready = 1'b0;
                    if (dbeat == c.wait_beat) c.wait_beat = -1;
                end else begin
                    bus.m_hrdata = mem(dp_addr);
                    dp = 0;
                end
            end
            prev_wait = !bus.m_hready && !bus.m_hresp && bus.m_htrans[1];
            prev_tr = bus.m_htrans;
            prev_ad = bus.m_haddr;
            if (bus.m_hready && bus.m_htrans[1]) begin
                chk("htrans_kind", bus.m_htrans, in_burst ? 2'b11 : 2'b10);
                if (!in_burst) begin
                    if (slave_q.size() == 0) timeout("burst_without_request");
                    else c = slave_q.pop_front();
                    beat = 0;
                    in_burst = 1;
                end
                chk("haddr", bus.m_haddr, beat_addr(c.addr, beat));
                dp = 1; dp_addr = bus.m_haddr; dbeat = beat;
                beat++;
                if (beat == LW) in_burst = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  tr_tab [5];
        logic [31:0] ad_tab [4];
        cfg_t c;
        int ends_before;
        tr_tab = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00};
        ad_tab = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        seed = $urandom;
        bus.miss_req = 1'b0;
        bus.miss_addr = '0;

        repeat (3) @(negedge hclk);
        chk("rst_htrans", bus.m_htrans, 2'b00);
        chk("rst_haddr", bus.m_haddr, 0);
        chk("rst_hburst", bus.m_hburst, 3'b010);
        chk("rst_hsize", bus.m_hsize, 3'b010);
        chk("rst_hwrite", bus.m_hwrite, 0);
        chk("rst_flags", {bus.busy, bus.refill_done, bus.refill_err, bus.crit_valid, bus.miss_ack}, 0);
        chk("rst_line", bus.refill_line, 0);
        chk("rst_index_tag", {bus.refill_index, bus.refill_tag}, 0);
        chk("rst_crit_data", bus.crit_data, 0);
        @(posedge hclk); #1 hrst = 1'b0;

        // Zero-wait refill with explicit per-cycle bus trace.
        c = mk(32'h1008, -1, -1, 0);
        issue(c);
        for (int k = 0; k < 5; k++) begin
            @(negedge hclk);
            chk("t1_htrans", bus.m_htrans, tr_tab[k]);
            if (k < 4) chk("t1_haddr", bus.m_haddr, ad_tab[k]);
            chk("t1_busy", bus.busy, 1);
        end
        wait_end();
        chk("t1_done_cycle", last_end_cyc - ack_cyc, 6);
        @(negedge hclk);
        chk("t1_busy_after", bus.busy, 0);
        repeat (3) @(negedge hclk);
        chk("t1_line_held", bus.refill_line, model(c).line);

        // One wait state on beat 2.
        issue(mk(32'h1000, -1, 2, 0));
        wait_end();
        chk("t2_done_cycle", last_end_cyc - ack_cyc, 7);

        // ERROR on beat 1, next request waiting behind it.
        issue(mk(32'h1040, 1, -1, 0));
        issue(mk(32'h1080, -1, -1, 0));
        chk("t3_ack_after_err", ack_cyc - last_end_cyc, 1);
        wait_end();

        // Miss arriving while busy is held off until after DONE.
        issue(mk(32'h1000, -1, -1, 0));
        issue(mk(32'h2000, -1, -1, 0));
        chk("t4_ack_after_done", ack_cyc - last_end_cyc, 1);
        wait_end();

        // Asynchronous reset mid-burst.
        issue(mk(32'h1000, -1, -1, 0));
        ends_before = n_end;
        @(posedge hclk);
        @(posedge hclk); #2 hrst = 1'b1;
        #1;
        chk("t5_rst_htrans", bus.m_htrans, 2'b00);
        chk("t5_rst_haddr", bus.m_haddr, 0);
        chk("t5_rst_flags", {bus.busy, bus.refill_done, bus.refill_err}, 0);
        chk("t5_rst_line", bus.refill_line, 0);
        exp_q.delete();
        slave_q.delete();
        n_issued = n_end;
        repeat (2) @(posedge hclk);
        #1 hrst = 1'b0;
        repeat (3) @(negedge hclk);
        chk("t5_no_end_pulse", n_end, ends_before);
        issue(mk(32'h1000, -1, -1, 0));
        wait_end();
        chk("t5_post_rst_cycle", last_end_cyc - ack_cyc, 6);

        // Critical word at the top of the line.
        issue(mk(32'h100C, -1, -1, 0));
        wait_end();
`ifdef ICACHE_CRIT_WORD_FWD_EN
        chk("t6_crit_cycle", crit_cyc - ack_cyc, 3);
`endif

        for (int n = 0; n < 40; n++) begin
            int pct_sel;
            pct_sel = $urandom_range(2);
            c = mk($urandom, ($urandom_range(9) == 0) ? $urandom_range(LW-1) : -1, -1,
                   (pct_sel == 0) ? 0 : (pct_sel == 1) ? 20 : 50);
            issue(c);
            if ($urandom_range(1) == 1) wait_end();
            repeat ($urandom_range(2)) @(negedge hclk);
        end
        wait_end();
        repeat (4) @(negedge hclk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
